// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver: synchronises the raw PS/2 lines, deserialises
// 11-bit device-to-host frames and decodes make / break (F0) / extended (E0) codes
// into the press level, done pulse and scancode consumed by the entry FSM.
// Optional build macro: PS2_PARITY_CHECK_EN enables odd-parity checking; without it
// the parity bit is sampled but ignored.
module ps2_scancode_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned TO_W           = 16,
   parameter logic [7:0]  ENTER_CODE     = 8'h5A
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       press,
   output logic       done,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       key_valid,
   output logic       frame_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DATA   = 3'd1;
   localparam logic [2:0] S_PARITY = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_DECODE = 3'd4;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   logic            clk_s1_q, clk_s2_q, clk_prev_q;
   logic            dat_s1_q, dat_s2_q;
   logic            fall;
   logic            par_ok;
   logic [2:0]      state_q, state_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            err_d;
   logic            ext_flag_q, brk_flag_q;
   logic            press_q, done_q, extended_q, key_valid_q, frame_err_q;
   logic [7:0]      scancode_q;

   assign fall   = clk_prev_q & ~clk_s2_q;
   // Odd parity over data + parity bit; forced good when checking is compiled out.
   assign par_ok = (^{shift_q, par_q}) | ~PARITY_EN;

   // Two-flop synchronisers for both pad lines plus the edge-detect history flop.
   // They reset to the idle-high bus level so reset release cannot fake a falling edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat;
         dat_s2_q   <= dat_s1_q;
      end
   end

   // Frame FSM next-state, shift/parity capture and inter-edge timeout.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      err_d    = 1'b0;
      if ((state_q == S_IDLE) || fall) to_d = '0;
      else                             to_d = to_q + TO_W'(1);
      case (state_q)
         S_IDLE: begin
            if (fall && !dat_s2_q) begin
               state_d  = S_DATA;
               bitcnt_d = 3'd0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d  = {dat_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               if (dat_s2_q && par_ok) begin
                  state_d = S_DECODE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_DECODE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // A stalled frame is abandoned; the prefix flags live elsewhere and survive.
      if (((state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP)) &&
          !fall && (to_q >= TO_LIMIT)) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end
   end

   // Frame FSM state registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         bitcnt_q <= 3'd0;
         shift_q  <= 8'h00;
         par_q    <= 1'b0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         to_q     <= to_d;
      end
   end

   // Byte decode: prefix tracking, make/break handling and registered output pulses.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ext_flag_q  <= 1'b0;
         brk_flag_q  <= 1'b0;
         press_q     <= 1'b0;
         done_q      <= 1'b0;
         scancode_q  <= 8'h00;
         extended_q  <= 1'b0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         key_valid_q <= 1'b0;
         frame_err_q <= err_d;
         if (state_q == S_DECODE) begin
            if (shift_q == 8'hE0) begin
               ext_flag_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
               brk_flag_q <= 1'b1;
            end else begin
               if (!brk_flag_q) begin
                  scancode_q  <= shift_q;
                  extended_q  <= ext_flag_q;
                  press_q     <= 1'b1;
                  key_valid_q <= 1'b1;
                  done_q      <= (shift_q == ENTER_CODE);
               end else if ((shift_q == scancode_q) && (ext_flag_q == extended_q)) begin
                  press_q <= 1'b0;
               end
               ext_flag_q <= 1'b0;
               brk_flag_q <= 1'b0;
            end
         end
      end
   end

   assign press     = press_q;
   assign done      = done_q;
   assign scancode  = scancode_q;
   assign extended  = extended_q;
   assign key_valid = key_valid_q;
   assign frame_err = frame_err_q;

endmodule
